iob_cache_be_lat_ram: RTL and testbench



---
 rtl/iob_cache_be_lat_ram_pkg.sv | 26 ++
 rtl/iob_cache_be_lfsr.sv | 27 ++
 rtl/iob_cache_be_lat_ram.sv | 166 ++++++++++++++++
 tb/tb_iob_cache_be_lat_ram.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_lat_ram_pkg.sv
// Shared types and constants for the latency-injecting back-end RAM model
// and its LFSR helper.
package iob_cache_be_lat_ram_pkg;

  // Request sequencer states: IDLE accepts, WAIT counts down the latency.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Transaction counter width.
  localparam int CNT_W = 32;

  // Latency arithmetic width: 255 fixed + 255 jitter fits in 9 bits.
  localparam int LAT_W = 9;

  // One Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/iob_cache_be_lfsr.sv
// 16-bit Galois LFSR that advances one step whenever en_i is high.
// Reusable jitter source for bench-side memory models.
module iob_cache_be_lfsr
  import iob_cache_be_lat_ram_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_reg;

  // Advance the sequence on enable; reset reloads the (non-zero) seed.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lfsr_reg <= SEED;
    end else if (en_i) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign lfsr_o = lfsr_reg;

endmodule

// File: rtl/iob_cache_be_lat_ram.sv
// Back-end memory model for the cache's IOb-native port. Each request is
// held for LAT (+ optional LFSR jitter) cycles before it touches memory,
// so the cache sees realistic stalls on accept and on read response.
module iob_cache_be_lat_ram
  import iob_cache_be_lat_ram_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter int          DATA_W     = 32,
  parameter int          MEM_ADDR_W = 12,
  parameter int          LAT        = 2,
  parameter int          RAND_W     = 0,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                ready_o,
  output logic [CNT_W-1:0]    rd_cnt_o,
  output logic [CNT_W-1:0]    wr_cnt_o
);

  localparam int NB    = DATA_W / 8;
  localparam int NB_W  = $clog2(NB);
  localparam int DEPTH = 1 << MEM_ADDR_W;
  // Jitter mask: zero when RAND_W==0, so no dependence on the LFSR at all.
  localparam logic [7:0] JIT_MASK = 8'((1 << RAND_W) - 1);

  state_t                state_reg, state_next;
  logic [LAT_W-1:0]      cnt_reg, cnt_next;
  logic [MEM_ADDR_W-1:0] idx_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [NB-1:0]         wstrb_reg;
  logic                  rvalid_reg;
  logic [CNT_W-1:0]      rd_cnt_reg, wr_cnt_reg;

  logic                  accept;
  logic [15:0]           lfsr;
  logic [LAT_W-1:0]      lat_eff;
  logic [MEM_ADDR_W-1:0] req_idx;
  logic                  exec;
  logic [MEM_ADDR_W-1:0] exec_idx;
  logic [DATA_W-1:0]     exec_wdata;
  logic [NB-1:0]         exec_wstrb;
  logic                  exec_rd, exec_wr;
  // Upper/lower address bits alias away; upper LFSR bits are never needed.
  logic                  unused_bits;

  assign unused_bits = ^{addr_i, lfsr};
  assign req_idx     = addr_i[NB_W+MEM_ADDR_W-1:NB_W];
  assign ready_o     = (state_reg == IDLE);
  assign accept      = valid_i & ready_o;
  assign lat_eff     = LAT_W'(LAT) + {1'b0, lfsr[7:0] & JIT_MASK};

  iob_cache_be_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .en_i    (accept),
    .lfsr_o  (lfsr)
  );

  // Sequencer: zero-latency requests execute straight from the port,
  // others are parked in WAIT and execute from the latched copy.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exec       = 1'b0;
    exec_idx   = idx_reg;
    exec_wdata = wdata_reg;
    exec_wstrb = wstrb_reg;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          if (lat_eff == '0) begin
            exec       = 1'b1;
            exec_idx   = req_idx;
            exec_wdata = wdata_i;
            exec_wstrb = wstrb_i;
          end else begin
            state_next = WAIT;
            cnt_next   = lat_eff;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == LAT_W'(1)) begin
          exec       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign exec_rd = exec & ~(|exec_wstrb);
  assign exec_wr = exec & (|exec_wstrb);

  // State, countdown and latched request; the latch loads on every accept.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= req_idx;
        wdata_reg <= wdata_i;
        wstrb_reg <= wstrb_i;
      end
    end
  end

  // Read-valid pulse and completion counters, stepped at execution time.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rvalid_reg <= 1'b0;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      rvalid_reg <= exec_rd;
      if (exec_rd) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
      if (exec_wr) wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
    end
  end

  assign rvalid_o = rvalid_reg;
  assign rd_cnt_o = rd_cnt_reg;
  assign wr_cnt_o = wr_cnt_reg;

  // One byte-wide RAM per lane so strobed writes map onto plain arrays.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_reg;

    // Lane write when its strobe is set.
    always_ff @(posedge clk_i) begin
      if (exec_wr && exec_wstrb[gi]) begin
        mem[exec_idx] <= exec_wdata[gi*8 +: 8];
      end
    end

    // Registered lane read; value holds between read responses.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        rdata_reg <= '0;
      end else if (exec_rd) begin
        rdata_reg <= mem[exec_idx];
      end
    end

    assign rdata_o[gi*8 +: 8] = rdata_reg;
  end

endmodule

// File: tb/tb_iob_cache_be_lat_ram.sv
// Bench for the latency RAM model: four instances with different latency
// settings share clock and reset; vectors, corner sequences and a random
// scoreboard run against them in turn.
module tb_iob_cache_be_lat_ram;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int BUDGET = 600;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid_s  [4];
  logic [AW-1:0] addr_s   [4];
  logic [DW-1:0] wdata_s  [4];
  logic [3:0]    wstrb_s  [4];
  logic [DW-1:0] rdata_s  [4];
  logic          rvalid_s [4];
  logic          ready_s  [4];
  logic [31:0]   rdc_s    [4];
  logic [31:0]   wrc_s    [4];

  // Instance 0: LAT=0, 1: LAT=3, 2: LAT=4, 3: LAT=1 with 3 jitter bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    iob_cache_be_lat_ram #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MEM_ADDR_W(12),
      .LAT       (gi == 0 ? 0 : gi == 1 ? 3 : gi == 2 ? 4 : 1),
      .RAND_W    (gi == 3 ? 3 : 0),
      .LFSR_SEED (16'hACE1)
    ) u_dut (
      .clk_i   (clk),
      .arst_n_i(arst_n),
      .valid_i (valid_s[gi]),
      .addr_i  (addr_s[gi]),
      .wdata_i (wdata_s[gi]),
      .wstrb_i (wstrb_s[gi]),
      .rdata_o (rdata_s[gi]),
      .rvalid_o(rvalid_s[gi]),
      .ready_o (ready_s[gi]),
      .rd_cnt_o(rdc_s[gi]),
      .wr_cnt_o(wrc_s[gi])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on instance d (called just after a rising edge) and
  // return once ready is back high, with the stall length and the response
  // observed in that cycle.
  task automatic do_req(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [3:0] ws, output int stall, output logic rv,
                        output logic [DW-1:0] rd);
    valid_s[d] = 1'b1;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    wstrb_s[d] = ws;
    @(posedge clk); #1;
    valid_s[d] = 1'b0;
    stall = 0;
    while (!ready_s[d] && stall < BUDGET) begin
      chk("rvalid_during_stall", {31'd0, rvalid_s[d]}, 32'd0);
      @(posedge clk); #1;
      stall++;
    end
    if (stall >= BUDGET) chk("ready_timeout", {31'd0, ready_s[d]}, 32'd1);
    rv = rvalid_s[d];
    rd = rdata_s[d];
    $display("tx dut%0d addr=%h wstrb=%h wdata=%h stall=%0d rvalid=%b rdata=%h",
             d, a, ws, wd, stall, rv, rd);
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    ws;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    int            e_rdc;
    int            e_wrc;
  } vec_t;

  vec_t tab [10];

  // Reference memory for the random phase: word contents plus which bytes
  // have ever been written.
  logic [31:0] mdl   [4096];
  logic [3:0]  known [4096];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            st;
    logic          rv;
    logic [DW-1:0] rd;
    int            nrd, nwr;

    for (int i = 0; i < 4; i++) begin
      valid_s[i] = 1'b0;
      addr_s[i]  = '0;
      wdata_s[i] = '0;
      wstrb_s[i] = '0;
    end

    // ---------------- reset state ----------------
    repeat (5) @(posedge clk);
    #1 arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready",  {31'd0, ready_s[i]},  32'd1);
      chk("reset_rvalid", {31'd0, rvalid_s[i]}, 32'd0);
      chk("reset_rdata",  rdata_s[i], 32'd0);
      chk("reset_rd_cnt", rdc_s[i],   32'd0);
      chk("reset_wr_cnt", wrc_s[i],   32'd0);
    end

    // ---------------- reset while a write is pending (LAT=4) ----------------
    do_req(2, 24'h000080, 32'h01020304, 4'hF, st, rv, rd);
    chk("lat4_write_stall", st, 4);
    chk("lat4_write_cnt", wrc_s[2], 32'd1);
    valid_s[2] = 1'b1; addr_s[2] = 24'h000080; wdata_s[2] = 32'hFFFFFFFF; wstrb_s[2] = 4'hF;
    @(posedge clk); #1;
    valid_s[2] = 1'b0;
    chk("midwait_ready_low", {31'd0, ready_s[2]}, 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    chk("midwait_reset_ready",  {31'd0, ready_s[2]}, 32'd1);
    chk("midwait_reset_wr_cnt", wrc_s[2], 32'd0);
    chk("midwait_reset_rvalid", {31'd0, rvalid_s[2]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    chk("midwait_release_ready", {31'd0, ready_s[2]}, 32'd1);
    do_req(2, 24'h000080, 32'h0, 4'h0, st, rv, rd);
    chk("midwait_read_stall",  st, 4);
    chk("midwait_read_rvalid", {31'd0, rv}, 32'd1);
    chk("midwait_mem_kept",    rd, 32'h01020304);
    chk("midwait_rd_cnt", rdc_s[2], 32'd1);
    chk("midwait_wr_cnt", wrc_s[2], 32'd0);

    // ---------------- zero-latency vector table ----------------
    tab[0] = '{1'b1, 24'h000010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 0, 1};
    tab[1] = '{1'b1, 24'h000010, 32'h00000000, 4'h0, 1'b1, 32'hDEADBEEF, 1, 1};
    tab[2] = '{1'b0, 24'h000000, 32'h00000000, 4'h0, 1'b0, 32'hDEADBEEF, 1, 1};
    tab[3] = '{1'b1, 24'h000020, 32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF, 1, 2};
    tab[4] = '{1'b1, 24'h000020, 32'hAABBCCDD, 4'h5, 1'b0, 32'hDEADBEEF, 1, 3};
    tab[5] = '{1'b1, 24'h000020, 32'h00000000, 4'h0, 1'b1, 32'h11BB33DD, 2, 3};
    tab[6] = '{1'b1, 24'h004000, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h11BB33DD, 2, 4};
    tab[7] = '{1'b1, 24'h000000, 32'h00000000, 4'h0, 1'b1, 32'h5A5A5A5A, 3, 4};
    tab[8] = '{1'b1, 24'hFF0013, 32'h00000000, 4'h0, 1'b1, 32'hDEADBEEF, 4, 4};
    tab[9] = '{1'b0, 24'h000000, 32'h00000000, 4'h0, 1'b0, 32'hDEADBEEF, 4, 4};
    for (int i = 0; i < 10; i++) begin
      valid_s[0] = tab[i].v;
      addr_s[0]  = tab[i].a;
      wdata_s[0] = tab[i].wd;
      wstrb_s[0] = tab[i].ws;
      @(posedge clk); #1;
      valid_s[0] = 1'b0;
      $display("tx dut0 vec=%0d valid=%b addr=%h wstrb=%h rvalid=%b rdata=%h",
               i, tab[i].v, tab[i].a, tab[i].ws, rvalid_s[0], rdata_s[0]);
      chk($sformatf("vec%0d_ready", i),  {31'd0, ready_s[0]},  32'd1);
      chk($sformatf("vec%0d_rvalid", i), {31'd0, rvalid_s[0]}, {31'd0, tab[i].e_rv});
      chk($sformatf("vec%0d_rdata", i),  rdata_s[0], tab[i].e_rd);
      chk($sformatf("vec%0d_rd_cnt", i), rdc_s[0], tab[i].e_rdc);
      chk($sformatf("vec%0d_wr_cnt", i), wrc_s[0], tab[i].e_wrc);
    end

    // ---------------- fixed latency 3 ----------------
    do_req(1, 24'h000044, 32'hC0FFEE00, 4'hF, st, rv, rd);
    chk("lat3_write_stall",  st, 3);
    chk("lat3_write_rvalid", {31'd0, rv}, 32'd0);
    chk("lat3_write_cnt",    wrc_s[1], 32'd1);
    do_req(1, 24'h000044, 32'h0, 4'h0, st, rv, rd);
    chk("lat3_read_stall",  st, 3);
    chk("lat3_read_rvalid", {31'd0, rv}, 32'd1);
    chk("lat3_read_data",   rd, 32'hC0FFEE00);
    chk("lat3_read_cnt",    rdc_s[1], 32'd1);
    @(posedge clk); #1;
    chk("lat3_rvalid_pulse", {31'd0, rvalid_s[1]}, 32'd0);
    chk("lat3_rdata_hold",   rdata_s[1], 32'hC0FFEE00);

    // ---------------- random traffic with jitter ----------------
    for (int w = 0; w < 4096; w++) begin
      mdl[w]   = '0;
      known[w] = '0;
    end
    nrd = 0;
    nwr = 0;
    for (int t = 0; t < 1000; t++) begin
      logic [11:0]   idx;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      logic [3:0]    ws;
      logic [31:0]   m;
      idx = 12'($urandom_range(0, 15));
      a   = {10'($urandom), idx, 2'($urandom)};
      wd  = $urandom;
      ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      chk("rand_ready_idle", {31'd0, ready_s[3]}, 32'd1);
      do_req(3, a, wd, ws, st, rv, rd);
      chk("rand_stall_range", {31'd0, (st >= 1 && st <= 8)}, 32'd1);
      if (ws == 4'h0) begin
        nrd++;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = known[idx][b] ? 8'hFF : 8'h00;
        chk("rand_read_rvalid", {31'd0, rv}, 32'd1);
        chk("rand_read_data", rd & m, mdl[idx] & m);
      end else begin
        nwr++;
        chk("rand_write_rvalid", {31'd0, rv}, 32'd0);
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) begin
            mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
            known[idx][b]      = 1'b1;
          end
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("rand_idle_rvalid", {31'd0, rvalid_s[3]}, 32'd0);
      end
    end
    chk("rand_total_cnt", rdc_s[3] + wrc_s[3], 32'd1000);
    chk("rand_rd_cnt", rdc_s[3], nrd);
    chk("rand_wr_cnt", wrc_s[3], nwr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
